avalon_pio_ctrl: RTL and testbench
==================================

# avalon_pio_ctrl

Parametrised Avalon-MM parallel I/O port, successor to the fixed-width output-only PIO used on the NIOS bus for HPI and keyboard control lines. Each bit is individually configurable as input or output at run time. Outputs support atomic set and clear writes. Inputs are synchronised and edge-captured, with a maskable level interrupt to the NIOS IRQ controller.

## Interface
Parameters:
- WIDTH, 8, number of I/O bits, 1..32
- RESET_VALUE, 0, reset value of the output data register (WIDTH bits)
- DIR_RESET, 0, reset value of the direction register; 1 = output
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge
- SYNC_STAGES, 2, input synchroniser depth, 2..4

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational, zero wait states
- in_port  in  WIDTH  external pin inputs, asynchronous to clk
- out_port  out  WIDTH  output data register
- oe  out  WIDTH  per-bit output enable, equal to the direction register
- irq  out  1  interrupt, active-high level

## Operation
- Write occurs when chipselect=1 and write_n=0. writedata bits at or above WIDTH are ignored.
- Register map:
  - 0 DATA. Write loads data_out. Read returns, per bit, data_out where dir=1 and the synchronised input where dir=0.
  - 1 DIR. Read/write.
  - 2 IRQ_MASK. Read/write; reset 0.
  - 3 EDGE_CAP. Read returns capture bits. Write-1-to-clear per bit.
  - 4 OUTSET. Write: data_out |= writedata. Reads 0.
  - 5 OUTCLR. Write: data_out &= ~writedata. Reads 0.
  - 6, 7. Reserved; read 0, writes ignored.
- readdata[31:WIDTH] is always 0.
- Input path:
  - in_port passes through SYNC_STAGES flops giving sync_in, then one further flop giving prev_in.
  - Edge detect, per EDGE_TYPE:
    - rising: sync_in & ~prev_in
    - falling: ~sync_in & prev_in
    - any: sync_in ^ prev_in
  - Only bits with dir=0 set capture.
- Capture bits are sticky until cleared. If a capture set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq = |(edge_cap & irq_mask), combinational from registers.
- Changing DIR does not alter data_out or edge_cap.
- Reset values:
  - data_out = RESET_VALUE
  - dir = DIR_RESET
  - irq_mask = 0
  - edge_cap = 0
  - sync and prev flops = 0
  - irq = 0
- Reset mid-operation returns all state to these values immediately and asynchronously.
- The synchroniser is reset to 0. For inputs held high through reset release, a spurious rising edge is therefore captured SYNC_STAGES+1 cycles after release. This is required behaviour; software clears EDGE_CAP after init.

## Timing
- Register writes take effect at the clk edge on which the write is sampled. out_port and oe change one cycle after the write strobe.
- readdata is valid in the same cycle as address (Avalon read latency 0).
- A read of EDGE_CAP in the cycle that a W1C write is sampled returns the pre-clear value.
- Input latency, with in_port changing before edge 0:
  - sync_in reflects the change after edge SYNC_STAGES.
  - edge_cap and irq assert after edge SYNC_STAGES+1. Default: 3 cycles.
- Pulses on in_port shorter than one clk period may be missed. Pulses of at least 2 periods are always captured.

## Structure
- Package avalon_pio_pkg holds:
  - address localparams ADDR_DATA..ADDR_OUTCLR
  - EDGE_RISING, EDGE_FALLING, EDGE_ANY constants
- Sub-module pio_sync_edge (parameters WIDTH, SYNC_STAGES, EDGE_TYPE) contains the synchroniser, prev register and edge-detect logic. It outputs sync_in and edge_pulse.
- The top level holds the register file, the read mux and the irq logic.

## Test plan
- Reset with WIDTH=8, RESET_VALUE=8'hA5, DIR_RESET=8'h0F -> out_port=A5, oe=0F, irq=0, readdata of EDGE_CAP=0.
- Write DATA=8'h3C, then OUTSET=8'h01, then OUTCLR=8'h20 -> out_port sequence 3C, 3D, 1D, each change one cycle after its write; writedata[31:8] has no effect.
- DIR=8'h0F with in_port=8'hB0 and data_out=8'h05 -> DATA read returns 8'hB5 once SYNC_STAGES cycles have elapsed.
- EDGE_TYPE=0, IRQ_MASK=8'h80, DIR=0; in_port[7] rises -> EDGE_CAP[7]=1 and irq=1 exactly 3 cycles later. In_port[0] rising with mask bit 0 clear -> EDGE_CAP[0]=1 and irq unchanged.
- Write EDGE_CAP=8'h80 in the same cycle that a new bit-7 edge is detected -> bit stays 1. A clear with no concurrent edge -> bit 0, irq deasserts next cycle.
- Assert reset_n low asynchronously while irq=1 and out_port=FF -> irq and out_port go to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon-MM PIO: register addresses and edge-capture modes.
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser for the PIO pins, followed by a one-flop history register and
// per-bit edge detection on the synchronised value.
module pio_sync_edge
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_in;

    // Stage 0 takes the raw pin; the last stage is the metastability-safe value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            prev_in <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev_in <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_TYPE == EDGE_FALLING) begin : g_falling
            assign edge_pulse = ~sync_in & prev_in;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_pulse = sync_in ^ prev_in;
        end else begin : g_rising
            assign edge_pulse = sync_in & ~prev_in;
        end
    endgenerate

endmodule

// File: rtl/avalon_pio_ctrl.sv
// Avalon-MM parallel I/O port with per-bit direction, atomic set/clear of outputs,
// sticky edge capture on inputs and a maskable level interrupt.
module avalon_pio_ctrl
    import avalon_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               EDGE_TYPE   = EDGE_RISING,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] wr_bits;
    logic [WIDTH-1:0] cap_clear;
    logic [WIDTH-1:0] rd_bits;
    logic             wr_en;
    logic             unused_writedata;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .sync_in    (sync_in),
        .edge_pulse (edge_pulse)
    );

    assign wr_en            = chipselect && !write_n;
    assign wr_bits          = writedata[WIDTH-1:0];
    assign unused_writedata = ^writedata;
    assign cap_clear        = (wr_en && address == ADDR_EDGE_CAP) ? wr_bits : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
            dir      <= DIR_RESET;
            irq_mask <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:     data_out <= wr_bits;
                ADDR_DIR:      dir      <= wr_bits;
                ADDR_IRQ_MASK: irq_mask <= wr_bits;
                ADDR_OUTSET:   data_out <= data_out | wr_bits;
                ADDR_OUTCLR:   data_out <= data_out & ~wr_bits;
                default:       ;
            endcase
        end
    end

    // A new edge in the same cycle as a W1C clear must survive, so the set term is ORed last.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clear) | (edge_pulse & ~dir);
        end
    end

    always_comb begin
        rd_bits = '0;
        case (address)
            ADDR_DATA:     rd_bits = (data_out & dir) | (sync_in & ~dir);
            ADDR_DIR:      rd_bits = dir;
            ADDR_IRQ_MASK: rd_bits = irq_mask;
            ADDR_EDGE_CAP: rd_bits = edge_cap;
            default:       rd_bits = '0;
        endcase
        readdata              = '0;
        readdata[WIDTH-1:0]   = rd_bits;
    end

    assign out_port = data_out;
    assign oe       = dir;
    assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_avalon_pio_ctrl.sv
// Self-checking bench for avalon_pio_ctrl: directed scenarios plus randomized bus and pin
// activity compared against a delay-line reference model of the port.
module tb_avalon_pio_ctrl;
    import avalon_pio_pkg::*;

    localparam int         WIDTH       = 8;
    localparam int         SYNC_STAGES = 2;
    localparam int         EDGE_TYPE   = EDGE_RISING;
    localparam logic [7:0] RESET_VALUE = 8'hA5;
    localparam logic [7:0] DIR_RESET   = 8'h0F;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    int check_count = 0;
    int fail_count  = 0;

    logic [7:0] m_data;
    logic [7:0] m_dir;
    logic [7:0] m_mask;
    logic [7:0] m_cap;
    logic [7:0] hist[$];

    avalon_pio_ctrl #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .DIR_RESET   (DIR_RESET),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe         (oe),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    // hist[k] is the pin value sampled k+1 edges ago, so sync_in is hist[SYNC_STAGES-1].
    task automatic modelReset();
        m_data = RESET_VALUE;
        m_dir  = DIR_RESET;
        m_mask = 8'h00;
        m_cap  = 8'h00;
        hist.delete();
        for (int i = 0; i <= SYNC_STAGES; i++) hist.push_back(8'h00);
    endtask

    function automatic logic [31:0] modelRead(input logic [2:0] a);
        logic [7:0] pins;
        pins = hist[SYNC_STAGES-1];
        case (a)
            3'd0:    return {24'h0, (m_data & m_dir) | (pins & ~m_dir)};
            3'd1:    return {24'h0, m_dir};
            3'd2:    return {24'h0, m_mask};
            3'd3:    return {24'h0, m_cap};
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelStep();
        logic [7:0] cur;
        logic [7:0] prv;
        logic [7:0] edges;
        logic [7:0] w;
        logic [7:0] clr;
        bit         wr;
        cur   = hist[SYNC_STAGES-1];
        prv   = hist[SYNC_STAGES];
        edges = (EDGE_TYPE == EDGE_FALLING) ? (~cur & prv) :
                (EDGE_TYPE == EDGE_ANY)     ? (cur ^ prv)  : (cur & ~prv);
        wr    = chipselect && !write_n;
        w     = writedata[7:0];
        clr   = (wr && address == 3'd3) ? w : 8'h00;
        m_cap = (m_cap & ~clr) | (edges & ~m_dir);
        if (wr) begin
            case (address)
                3'd0: m_data = w;
                3'd1: m_dir  = w;
                3'd2: m_mask = w;
                3'd4: m_data = m_data | w;
                3'd5: m_data = m_data & ~w;
                default: ;
            endcase
        end
        hist.push_front(in_port);
        void'(hist.pop_back());
    endtask

    task automatic checkAll();
        checkOutput("out_port", {24'h0, out_port}, {24'h0, m_data});
        checkOutput("oe", {24'h0, oe}, {24'h0, m_dir});
        checkOutput("irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
        checkOutput("readdata", readdata, modelRead(address));
    endtask

    // Entered at a negedge: drive, check pre-edge state, clock once, advance the model.
    task automatic applyStimulus(input logic cs, input logic wn, input logic [2:0] addr,
                                 input logic [31:0] wd, input logic [7:0] pins);
        chipselect = cs;
        write_n    = wn;
        address    = addr;
        writedata  = wd;
        in_port    = pins;
        #1;
        checkAll();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic writeReg(input logic [2:0] addr, input logic [31:0] wd, input logic [7:0] pins);
        applyStimulus(1'b1, 1'b0, addr, wd, pins);
    endtask

    task automatic idle(input logic [2:0] addr, input logic [7:0] pins);
        applyStimulus(1'b0, 1'b0, addr, $urandom, pins);
    endtask

    initial begin
        logic [7:0] rand_pins;
        reset_n    = 1'b0;
        address    = 3'd3;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        modelReset();

        @(negedge clk);
        #1;
        checkOutput("rst_out_port", {24'h0, out_port}, 32'hA5);
        checkOutput("rst_oe", {24'h0, oe}, 32'h0F);
        checkOutput("rst_irq", {31'h0, irq}, 32'h0);
        checkOutput("rst_edge_cap", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        writeReg(3'd0, 32'hFFFF_FF3C, 8'h00);
        checkOutput("data_write", {24'h0, out_port}, 32'h3C);
        writeReg(3'd4, 32'hABCD_EF01, 8'h00);
        checkOutput("outset", {24'h0, out_port}, 32'h3D);
        writeReg(3'd5, 32'h1234_5620, 8'h00);
        checkOutput("outclr", {24'h0, out_port}, 32'h1D);
        idle(3'd4, 8'h00);
        checkOutput("outset_reads0", readdata, 32'h0);

        writeReg(3'd1, 32'h0F, 8'hB0);
        writeReg(3'd0, 32'h05, 8'hB0);
        idle(3'd0, 8'hB0);
        checkOutput("data_mixed", readdata, 32'hB5);

        writeReg(3'd1, 32'h00, 8'h00);
        writeReg(3'd2, 32'h80, 8'h00);
        writeReg(3'd3, 32'hFF, 8'h00);
        idle(3'd3, 8'h00);
        idle(3'd3, 8'h00);
        checkOutput("cap_cleared", readdata, 32'h0);
        idle(3'd3, 8'h80);
        idle(3'd3, 8'h80);
        checkOutput("irq_not_yet", {31'h0, irq}, 32'h0);
        idle(3'd3, 8'h80);
        checkOutput("irq_edge7", {31'h0, irq}, 32'h1);
        checkOutput("cap_edge7", readdata, 32'h80);
        idle(3'd3, 8'h81);
        idle(3'd3, 8'h81);
        idle(3'd3, 8'h81);
        checkOutput("cap_edge0_masked", readdata, 32'h81);
        checkOutput("irq_still", {31'h0, irq}, 32'h1);

        writeReg(3'd3, 32'hFF, 8'h81);
        idle(3'd3, 8'h00);
        idle(3'd3, 8'h00);
        idle(3'd3, 8'h00);
        idle(3'd3, 8'h80);
        idle(3'd3, 8'h80);
        writeReg(3'd3, 32'h80, 8'h80);
        checkOutput("set_wins", readdata, 32'h80);
        writeReg(3'd3, 32'h80, 8'h80);
        checkOutput("w1c_clear", readdata, 32'h0);
        checkOutput("irq_deassert", {31'h0, irq}, 32'h0);

        rand_pins = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) rand_pins = 8'($urandom);
            applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), $urandom, rand_pins);
        end

        writeReg(3'd1, 32'h00, 8'h00);
        writeReg(3'd0, 32'hFF, 8'h00);
        writeReg(3'd2, 32'hFF, 8'h00);
        writeReg(3'd3, 32'hFF, 8'h00);
        idle(3'd3, 8'h00);
        idle(3'd3, 8'h00);
        idle(3'd3, 8'hFF);
        idle(3'd3, 8'hFF);
        idle(3'd3, 8'hFF);
        checkOutput("pre_reset_irq", {31'h0, irq}, 32'h1);
        checkOutput("pre_reset_out", {24'h0, out_port}, 32'hFF);

        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_irq", {31'h0, irq}, 32'h0);
        checkOutput("async_rst_out", {24'h0, out_port}, 32'hA5);
        checkOutput("async_rst_oe", {24'h0, oe}, 32'h0F);
        checkOutput("async_rst_cap", readdata, 32'h0);
        modelReset();
        @(negedge clk);
        reset_n = 1'b1;

        // Pins held high through reset release look like a rising edge once synchronised.
        idle(3'd3, 8'hFF);
        idle(3'd3, 8'hFF);
        idle(3'd3, 8'hFF);
        checkOutput("spurious_edge", readdata, 32'hF0);
        idle(3'd3, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
